hidden_state_writeback: RTL and testbench
=========================================

Name: hidden_state_writeback

Overview:
- Closes the recurrent loop of the LSTM/RNN hidden layer.
- Collects the per-neuron activation outputs one at a time. Each output is the wide signed result of a neuron's bias-add and activation.
- Requantizes each output to the dataWidth hidden format with saturation, then assembles the packed hidden-state vector h(t).
- Presents h(t) as the stable `hid` bus consumed by every hidden neuron on the next timestep. It also tracks timesteps within a sequence.

Parameters:
- dataWidth, 5, width of one hidden-state element (signed, two's complement).
- fracWidth, 2, fractional bits of the hidden-state format.
- inFrac, 2, fractional bits of incoming activation outputs; must be >= fracWidth.
- hiddenSize, 3, number of hidden neurons/elements per vector.
- seqLen, 4, timesteps per sequence; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous sequence restart.
- in_valid  input  1  an activation output is present on in_data.
- in_data  input  2*dataWidth+1  signed activation output, inFrac fractional bits.
- in_ready  output  1  block accepts in_data this cycle.
- hid  output  dataWidth*hiddenSize  packed h(t); element j at [dataWidth*j +: dataWidth].
- hid_valid  output  1  hid holds a complete, committed vector.
- hid_ready  input  1  neuron array has latched hid and is starting a timestep.
- hid_last  output  1  presented vector is the final h of the sequence.
- step  output  $clog2(seqLen+1)  completed timesteps in the current sequence.
- seq_done  output  1  one-cycle pulse after the final commit of a sequence.
- sat_flag  output  1  sticky: some element saturated since the last rst/clear.

Behaviour:
- Reset (rst=1, async) sets:
  - state=PRESENT;
  - hid=0 and staging=0, so h0 = 0;
  - beat counter idx=0 and step=0;
  - hid_valid=1, in_ready=0, hid_last=0, seq_done=0, sat_flag=0.
- FSM states are PRESENT and COLLECT.
- PRESENT:
  - hid_valid=1 and in_ready=0; in_valid is ignored.
  - On hid_valid && hid_ready, at the next edge:
    - if hid_last=0: go to COLLECT with idx=0;
    - if hid_last=1: hid=0, staging=0, step=0, hid_last=0, stay in PRESENT (h0 of the next sequence).
- COLLECT:
  - hid_valid=0 and in_ready=1. hid holds its previous value, stable, throughout COLLECT.
  - Each handshake (in_valid && in_ready) writes q(in_data) into staging element idx and increments idx.
  - Beats arrive in neuron order 0..hiddenSize-1.
  - On the beat with idx=hiddenSize-1, in the same edge:
    - hid <= staging with that final element merged;
    - idx=0, step+=1;
    - state=PRESENT.
  - If step becomes seqLen: hid_last=1 and seq_done pulses in the following cycle.
- Requantization q(x), combinational, applied at capture:
  - Arithmetic shift right by (inFrac-fracWidth), rounding half-up by adding 1<<(inFrac-fracWidth-1) first when the shift is > 0.
  - Saturate to [-2^(dataWidth-1), 2^(dataWidth-1)-1], i.e. [-16,15] by default.
  - Any clamp sets sat_flag.
- Latency: last input beat to hid_valid=1 with the new hid is 1 cycle.
- The full hid vector updates atomically at commit; no partial vector is ever visible on hid.
- clear (sync) has priority over every handshake in the same cycle. It gives the reset state except that rst itself is not asserted.
- hid_ready while in COLLECT is ignored.
- in_valid in PRESENT is ignored and not stored. The producer must hold in_data until in_ready.
- rst mid-COLLECT discards the partial staging contents.

Decomposition:
- Shared package holds:
  - saturation bounds SAT_MAX/SAT_MIN as functions of dataWidth;
  - the rounding shift constant (inFrac-fracWidth);
  - the FSM state encoding (PRESENT=0, COLLECT=1).
- One natural sub-module, requant_sat: purely combinational shift/round/saturate. Ports: x in, y out, sat out. It is reusable for the output layer.

Test Plan:
- Reset: rst pulse -> hid=0, hid_valid=1, in_ready=0, step=0, sat_flag=0.
- Basic commit:
  - Stimulus: hid_ready for 1 cycle, then in_data 5, -3, 7 on consecutive cycles.
  - Response: hid={7,-3,5} (element 0 = 5) one cycle after the third beat; step=1; hid unchanged before the commit.
- Saturation:
  - Stimulus: in_data 40, -100, 15.
  - Response: elements 15, -16, 15; sat_flag=1 and it stays 1 through the next timestep.
- Rounding:
  - Stimulus: inFrac=4, fracWidth=2, in_data 6, 5, -6.
  - Response: elements 2, 1, -1; no saturation.
- Sequence end:
  - Stimulus: 4 full timesteps.
  - Response: seq_done pulses exactly once; hid_last=1 holds the 4th vector. Accepting it returns hid=0, step=0, hid_last=0.
- Disruption:
  - Stimulus: in_valid held high in PRESENT; clear asserted after 2 COLLECT beats; separately, rst asserted mid-COLLECT.
  - Response: the in_valid data is not stored; clear and rst each return hid=0, idx=0, state PRESENT, with no commit.

Source files
------------

// File: rtl/hidden_state_writeback_pkg.sv
// hidden_state_writeback_pkg
// Constants and types shared by the hidden-state writeback path and by any
// other block that requantizes wide activation results (e.g. the output layer).
//   state_t     : writeback FSM encoding (PRESENT=0, COLLECT=1)
//   sat_max/min : clamp bounds of a signed dataWidth-bit hidden element
//   round_shift : right shift taking inFrac fractional bits down to fracWidth
package hidden_state_writeback_pkg;

  typedef enum logic {
    PRESENT = 1'b0,
    COLLECT = 1'b1
  } state_t;

  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

  function automatic int round_shift(input int in_frac, input int frac_width);
    return in_frac - frac_width;
  endfunction

endpackage

// File: rtl/hidden_state_writeback_requant_sat.sv
// hidden_state_writeback_requant_sat
// Purely combinational requantizer: arithmetic shift right with round
// half-up, then saturation to a signed dataWidth-bit range.
//   x   : signed input, inWidth bits
//   y   : signed requantized result, dataWidth bits
//   sat : high when y was clamped to a bound
module hidden_state_writeback_requant_sat
  import hidden_state_writeback_pkg::*;
#(
  parameter int inWidth   = 11,
  parameter int dataWidth = 5,
  parameter int shift     = 0
) (
  input  logic signed [inWidth-1:0]   x,
  output logic signed [dataWidth-1:0] y,
  output logic                        sat
);

  // One guard bit so the rounding add can never wrap.
  localparam int EW = inWidth + 1;
  localparam logic signed [EW-1:0] MAXV = EW'(sat_max(dataWidth));
  localparam logic signed [EW-1:0] MINV = EW'(sat_min(dataWidth));

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rounded;
  logic signed [EW-1:0] shifted;

  assign ext = {x[inWidth-1], x};

  // The rounding constant only exists when bits are actually dropped.
  if (shift > 0) begin : g_round
    assign rounded = ext + EW'(1 << (shift - 1));
  end else begin : g_noround
    assign rounded = ext;
  end

  assign shifted = rounded >>> shift;

  always_comb begin
    sat = 1'b0;
    y   = shifted[dataWidth-1:0];
    if (shifted > MAXV) begin
      sat = 1'b1;
      y   = MAXV[dataWidth-1:0];
    end else if (shifted < MINV) begin
      sat = 1'b1;
      y   = MINV[dataWidth-1:0];
    end
  end

endmodule

// File: rtl/hidden_state_writeback.sv
// hidden_state_writeback
// Closes the recurrent loop: collects per-neuron activation outputs one beat
// at a time, requantizes them into staging, and commits the whole vector to
// the stable hid bus in one edge. Also counts timesteps within a sequence.
//   clk, rst        : clock, async active-high reset
//   clear           : sync sequence restart (beats any handshake)
//   in_valid/ready  : activation beat handshake, in_data is the wide result
//   hid/hid_valid   : committed h(t), element j at [dataWidth*j +: dataWidth]
//   hid_ready       : consumer latched hid and starts a timestep
//   hid_last        : presented vector is the final h of the sequence
//   step            : completed timesteps in this sequence
//   seq_done        : one-cycle pulse after the final commit
//   sat_flag        : sticky saturation indicator
module hidden_state_writeback
  import hidden_state_writeback_pkg::*;
#(
  parameter int dataWidth  = 5,
  parameter int fracWidth  = 2,
  parameter int inFrac     = 2,
  parameter int hiddenSize = 3,
  parameter int seqLen     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              in_valid,
  input  logic signed [2*dataWidth:0]       in_data,
  output logic                              in_ready,
  output logic [dataWidth*hiddenSize-1:0]   hid,
  output logic                              hid_valid,
  input  logic                              hid_ready,
  output logic                              hid_last,
  output logic [$clog2(seqLen+1)-1:0]       step,
  output logic                              seq_done,
  output logic                              sat_flag
);

  localparam int INW   = 2 * dataWidth + 1;
  localparam int STEPW = $clog2(seqLen + 1);
  localparam int IDXW  = (hiddenSize > 1) ? $clog2(hiddenSize) : 1;
  localparam int VW    = dataWidth * hiddenSize;

  state_t                   state, next_state;
  logic [VW-1:0]            staging;
  logic [VW-1:0]            merged;
  logic [IDXW-1:0]          idx;
  logic signed [dataWidth-1:0] q_y;
  logic                     q_sat;
  logic                     last_beat;

  hidden_state_writeback_requant_sat #(
    .inWidth  (INW),
    .dataWidth(dataWidth),
    .shift    (round_shift(inFrac, fracWidth))
  ) u_requant (
    .x  (in_data),
    .y  (q_y),
    .sat(q_sat)
  );

  assign last_beat = (idx == IDXW'(hiddenSize - 1));

  // Staging with the current beat already merged, so the final beat can be
  // committed to hid in the same edge that captures it.
  always_comb begin
    merged = staging;
    merged[dataWidth*idx +: dataWidth] = q_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PRESENT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    hid_valid  = 1'b0;
    in_ready   = 1'b0;
    case (state)
      PRESENT: begin
        hid_valid = 1'b1;
        if (hid_ready && !hid_last) next_state = COLLECT;
      end
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) next_state = PRESENT;
      end
      default: next_state = PRESENT;
    endcase
    if (clear) next_state = PRESENT;
  end

  // Datapath. Accepting a last vector rewinds to h0 of the next sequence
  // without leaving PRESENT; sat_flag only falls on rst/clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hid      <= '0;
      staging  <= '0;
      idx      <= '0;
      step     <= '0;
      hid_last <= 1'b0;
      seq_done <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (clear) begin
        hid      <= '0;
        staging  <= '0;
        idx      <= '0;
        step     <= '0;
        hid_last <= 1'b0;
        sat_flag <= 1'b0;
      end else if (state == PRESENT) begin
        if (hid_ready && hid_last) begin
          hid      <= '0;
          staging  <= '0;
          step     <= '0;
          hid_last <= 1'b0;
        end else if (hid_ready) begin
          idx <= '0;
        end
      end else if (in_valid) begin
        staging <= merged;
        if (q_sat) sat_flag <= 1'b1;
        if (last_beat) begin
          hid  <= merged;
          idx  <= '0;
          step <= step + STEPW'(1);
          if (step == STEPW'(seqLen - 1)) begin
            hid_last <= 1'b1;
            seq_done <= 1'b1;
          end
        end else begin
          idx <= idx + IDXW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hidden_state_writeback.sv
// tb_hidden_state_writeback
// Directed bench for hidden_state_writeback. A default instance covers reset,
// commit, saturation, sequence end, clear and mid-collect rst; a second
// instance with inFrac=4 covers round-half-up requantization.
module tb_hidden_state_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear, in_valid, hid_ready;
  logic [10:0] in_data;
  logic        in_ready, hid_valid, hid_last, seq_done, sat_flag;
  logic [14:0] hid;
  logic [2:0]  step;

  logic        r_clear, r_in_valid, r_hid_ready;
  logic [10:0] r_in_data;
  logic        r_in_ready, r_hid_valid, r_hid_last, r_seq_done, r_sat_flag;
  logic [14:0] r_hid;
  logic [2:0]  r_step;

  int tests = 0;
  int failures = 0;
  int seq_done_count = 0;

  always #5 clk = ~clk;

  hidden_state_writeback dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .hid(hid), .hid_valid(hid_valid), .hid_ready(hid_ready),
    .hid_last(hid_last), .step(step), .seq_done(seq_done), .sat_flag(sat_flag)
  );

  hidden_state_writeback #(.inFrac(4)) dutr (
    .clk(clk), .rst(rst), .clear(r_clear),
    .in_valid(r_in_valid), .in_data(r_in_data), .in_ready(r_in_ready),
    .hid(r_hid), .hid_valid(r_hid_valid), .hid_ready(r_hid_ready),
    .hid_last(r_hid_last), .step(r_step), .seq_done(r_seq_done), .sat_flag(r_sat_flag)
  );

  // Count seq_done pulses away from the active edge.
  always @(negedge clk) if (seq_done) seq_done_count++;

  function automatic logic [31:0] pack(input int e0, input int e1, input int e2);
    logic [4:0] a, b, c;
    a = 5'(e0);
    b = 5'(e1);
    c = 5'(e2);
    return 32'({c, b, a});
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the main instance for one cycle; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic c, input logic hr, input logic iv, input int d);
    clear     = c;
    hid_ready = hr;
    in_valid  = iv;
    in_data   = 11'(d);
    @(posedge clk);
    #1;
    clear     = 1'b0;
    hid_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic timestep(input int a, input int b, input int c);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, a);
    applyStimulus(1'b0, 1'b0, 1'b1, b);
    applyStimulus(1'b0, 1'b0, 1'b1, c);
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0; in_valid = 1'b0; hid_ready = 1'b0; in_data = '0;
    r_clear = 1'b0; r_in_valid = 1'b0; r_hid_ready = 1'b0; r_in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hid", 32'(hid), 32'd0);
    checkOutput("reset_hid_valid", 32'(hid_valid), 32'd1);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_step", 32'(step), 32'd0);
    checkOutput("reset_sat", 32'(sat_flag), 32'd0);
    checkOutput("reset_last", 32'(hid_last), 32'd0);
    rst = 1'b0;

    // Rounding instance: inFrac=4 -> shift 2 with +2 before the shift.
    r_hid_ready = 1'b1;
    @(posedge clk); #1;
    r_hid_ready = 1'b0;
    r_in_valid = 1'b1; r_in_data = 11'(6);
    @(posedge clk); #1;
    r_in_data = 11'(5);
    @(posedge clk); #1;
    r_in_data = 11'(-6);
    @(posedge clk); #1;
    r_in_valid = 1'b0;
    checkOutput("round_hid", 32'(r_hid), pack(2, 1, -1));
    checkOutput("round_sat", 32'(r_sat_flag), 32'd0);
    checkOutput("round_step", 32'(r_step), 32'd1);

    // in_valid while presenting must be ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 9);
    applyStimulus(1'b0, 1'b0, 1'b1, 9);
    checkOutput("present_ignore_hid", 32'(hid), 32'd0);
    checkOutput("present_ignore_valid", 32'(hid_valid), 32'd1);

    // Basic commit 5, -3, 7.
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("collect_in_ready", 32'(in_ready), 32'd1);
    checkOutput("collect_hid_valid", 32'(hid_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, -3);
    checkOutput("pre_commit_hid", 32'(hid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 7);
    checkOutput("commit_hid", 32'(hid), pack(5, -3, 7));
    checkOutput("commit_valid", 32'(hid_valid), 32'd1);
    checkOutput("commit_step", 32'(step), 32'd1);
    checkOutput("commit_sat", 32'(sat_flag), 32'd0);

    // Saturation 40, -100, 15.
    timestep(40, -100, 15);
    checkOutput("sat_hid", 32'(hid), pack(15, -16, 15));
    checkOutput("sat_flag", 32'(sat_flag), 32'd1);
    checkOutput("sat_step", 32'(step), 32'd2);

    timestep(1, 2, 3);
    checkOutput("sat_sticky", 32'(sat_flag), 32'd1);
    checkOutput("ts3_hid", 32'(hid), pack(1, 2, 3));
    checkOutput("ts3_last", 32'(hid_last), 32'd0);

    // Fourth timestep ends the sequence.
    timestep(0, -1, 4);
    checkOutput("ts4_hid", 32'(hid), pack(0, -1, 4));
    checkOutput("ts4_step", 32'(step), 32'd4);
    checkOutput("ts4_last", 32'(hid_last), 32'd1);
    checkOutput("ts4_seq_done", 32'(seq_done), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("seq_done_drop", 32'(seq_done), 32'd0);
    checkOutput("last_hold_hid", 32'(hid), pack(0, -1, 4));
    checkOutput("seq_done_once", 32'(seq_done_count), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("rewind_hid", 32'(hid), 32'd0);
    checkOutput("rewind_step", 32'(step), 32'd0);
    checkOutput("rewind_last", 32'(hid_last), 32'd0);
    checkOutput("rewind_present", 32'(hid_valid), 32'd1);

    // clear after two beats, colliding with a third beat.
    timestep(1, 2, 3);
    checkOutput("pre_clear_hid", 32'(hid), pack(1, 2, 3));
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 6);
    applyStimulus(1'b1, 1'b0, 1'b1, 7);
    checkOutput("clear_hid", 32'(hid), 32'd0);
    checkOutput("clear_valid", 32'(hid_valid), 32'd1);
    checkOutput("clear_step", 32'(step), 32'd0);
    checkOutput("clear_sat", 32'(sat_flag), 32'd0);
    timestep(4, 5, 6);
    checkOutput("post_clear_hid", 32'(hid), pack(4, 5, 6));
    checkOutput("post_clear_step", 32'(step), 32'd1);

    // rst in the middle of collecting.
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 9);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_hid", 32'(hid), 32'd0);
    checkOutput("rst_mid_valid", 32'(hid_valid), 32'd1);
    checkOutput("rst_mid_step", 32'(step), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    timestep(1, 1, 1);
    checkOutput("post_rst_hid", 32'(hid), pack(1, 1, 1));
    checkOutput("post_rst_step", 32'(step), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
